// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared types and encodings for the RV32M/RV64M multiply/
//                divide unit: FSM state enum, main-control qualifiers and the
//                eight funct3 operation codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  localparam logic [6:0] F7_MULDIV   = 7'b0000001;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit_if
//  Description : Request/response bundle between the EX stage and the
//                multiply/divide unit.
//                master : drives start, flush, ALUop, ALUctrl_f7/f3, op_a/b
//                slave  : drives md_sel, busy, done, result
//  Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [1:0]      ALUop;
  logic [6:0]      ALUctrl_f7;
  logic [2:0]      ALUctrl_f3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            md_sel;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, flush, ALUop, ALUctrl_f7, ALUctrl_f3, op_a, op_b,
    input  md_sel, busy, done, result
  );

  modport slave (
    input  start, flush, ALUop, ALUctrl_f7, ALUctrl_f3, op_a, op_b,
    output md_sel, busy, done, result
  );
endinterface
`default_nettype wire

// File: rtl/md_iter_core.sv
`default_nettype none
// ============================================================================
//  Module      : md_iter_core
//  Description : Unsigned radix-2 iteration datapath. One {hi,lo} register
//                pair serves both operations:
//                  multiply - lo holds the multiplier, hi accumulates; each
//                             step adds the multiplicand and shifts right.
//                  divide   - lo holds the dividend/quotient, hi the partial
//                             remainder; each step is one restoring trial.
//                Outputs are the values *after* the current step, so the
//                owner can register a final result in the same cycle last_o
//                is high.
//  Ports       : clk, reset  - clock, synchronous active-high reset
//                load_i      - load magnitudes and counter (XLEN-1)
//                step_i      - perform one iteration, decrement counter
//                op_div_i    - op kind sampled at load (1 = divide)
//                mag_a_i/b_i - unsigned operand magnitudes
//                last_o      - current step is the final one
//                prod_o      - 2*XLEN product magnitude
//                quot_o/rem_o- quotient / remainder magnitudes
//  Revision    : 1.0 - initial release
// ============================================================================
module md_iter_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              op_div_i,
  input  logic [XLEN-1:0]   mag_a_i,
  input  logic [XLEN-1:0]   mag_b_i,
  output logic              last_o,
  output logic [2*XLEN-1:0] prod_o,
  output logic [XLEN-1:0]   quot_o,
  output logic [XLEN-1:0]   rem_o
);

  localparam int CNT_W = $clog2(XLEN);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic             op_div_q, op_div_d;

  logic [XLEN:0]    w_acc;
  logic [XLEN:0]    w_shift;
  logic [XLEN:0]    w_trial;
  logic [XLEN-1:0]  w_hi_step, w_lo_step;

  // One iteration of the selected algorithm.
  always_comb begin
    w_acc     = lo_q[0] ? ({1'b0, hi_q} + {1'b0, m_q}) : {1'b0, hi_q};
    w_shift   = {hi_q, lo_q[XLEN-1]};
    w_trial   = w_shift - {1'b0, m_q};
    w_hi_step = w_acc[XLEN:1];
    w_lo_step = {w_acc[0], lo_q[XLEN-1:1]};
    if (op_div_q) begin
      // Remainder stays below the divisor, so bit XLEN of the trial is a
      // reliable borrow flag.
      if (!w_trial[XLEN]) begin
        w_hi_step = w_trial[XLEN-1:0];
        w_lo_step = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        w_hi_step = w_shift[XLEN-1:0];
        w_lo_step = {lo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    m_d      = m_q;
    op_div_d = op_div_q;
    if (load_i) begin
      cnt_d    = CNT_W'(XLEN - 1);
      hi_d     = '0;
      lo_d     = op_div_i ? mag_a_i : mag_b_i;
      m_d      = op_div_i ? mag_b_i : mag_a_i;
      op_div_d = op_div_i;
    end else if (step_i) begin
      cnt_d = cnt_q - CNT_W'(1);
      hi_d  = w_hi_step;
      lo_d  = w_lo_step;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      op_div_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      m_q      <= m_d;
      op_div_q <= op_div_d;
    end
  end

  assign last_o = (cnt_q == '0);
  assign prod_o = {w_hi_step, w_lo_step};
  assign quot_o = w_lo_step;
  assign rem_o  = w_hi_step;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Multi-cycle RV32M/RV64M multiply/divide unit beside the EX
//                ALU. Decodes its own select, converts signed operands to
//                magnitudes, iterates in md_iter_core, applies the sign
//                fix-up and pulses done for one cycle.
//                Divide-by-zero and signed overflow finish in one cycle.
//                Optional macro MULDIV_FAST_MUL_EN: multiplies use a single
//                combinational product registered at accept (one cycle).
//  Ports       : clk, reset - clock, synchronous active-high reset
//                bus (slave) - start/flush/ALUop/ALUctrl_f7/f3/op_a/op_b in,
//                              md_sel/busy/done/result out
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  bus
);

  md_state_e        state_q, state_d;
  logic [2:0]       f3_q, f3_d;
  logic             neg_q, neg_d;
  logic [XLEN-1:0]  result_q, result_d;

  logic             w_md_sel, w_accept, w_busy, w_load;
  logic             w_sign_a, w_sign_b, w_neg;
  logic [XLEN-1:0]  w_mag_a, w_mag_b;
  logic             w_div0, w_ovf;
  logic [XLEN-1:0]  w_special_res, w_fast_res, w_final_res;

  logic             w_last;
  logic [2*XLEN-1:0] w_prod, w_prod_fix;
  logic [XLEN-1:0]  w_quot, w_rem, w_quot_fix, w_rem_fix;

  assign w_md_sel = (bus.ALUop == ALUOP_RTYPE) && (bus.ALUctrl_f7 == F7_MULDIV);
  assign w_busy   = (state_q == MUL) || (state_q == DIV);
  assign w_accept = bus.start && w_md_sel && !bus.flush &&
                    ((state_q == IDLE) || (state_q == DONE));

  // Operand a is signed for MULH/MULHSU/DIV/REM, operand b for MULH/DIV/REM.
  always_comb begin
    w_sign_a = 1'b0;
    w_sign_b = 1'b0;
    case (bus.ALUctrl_f3)
      F3_MULH, F3_DIV, F3_REM: begin
        w_sign_a = bus.op_a[XLEN-1];
        w_sign_b = bus.op_b[XLEN-1];
      end
      F3_MULHSU: w_sign_a = bus.op_a[XLEN-1];
      default: ;
    endcase
    // Remainder follows the dividend; everything else follows the xor.
    w_neg = (bus.ALUctrl_f3[2] && bus.ALUctrl_f3[1]) ? w_sign_a : (w_sign_a ^ w_sign_b);
  end

  assign w_mag_a = w_sign_a ? (-bus.op_a) : bus.op_a;
  assign w_mag_b = w_sign_b ? (-bus.op_b) : bus.op_b;

  assign w_div0 = bus.ALUctrl_f3[2] && (bus.op_b == '0);
  assign w_ovf  = bus.ALUctrl_f3[2] && !bus.ALUctrl_f3[0] &&
                  (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);

  always_comb begin
    if (w_div0) w_special_res = bus.ALUctrl_f3[1] ? bus.op_a : '1;
    else        w_special_res = bus.ALUctrl_f3[1] ? '0 : bus.op_a;
  end

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
  logic [2*XLEN-1:0] w_fast_prod;
  always_comb begin
    w_fast_prod = {{XLEN{1'b0}}, w_mag_a} * {{XLEN{1'b0}}, w_mag_b};
    if (w_neg) w_fast_prod = -w_fast_prod;
    w_fast_res = (bus.ALUctrl_f3 == F3_MUL) ? w_fast_prod[XLEN-1:0]
                                            : w_fast_prod[2*XLEN-1:XLEN];
  end
`else
  localparam bit FAST_MUL = 1'b0;
  assign w_fast_res = '0;
`endif

  md_iter_core #(.XLEN(XLEN)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load_i   (w_load),
    .step_i   (w_busy),
    .op_div_i (bus.ALUctrl_f3[2]),
    .mag_a_i  (w_mag_a),
    .mag_b_i  (w_mag_b),
    .last_o   (w_last),
    .prod_o   (w_prod),
    .quot_o   (w_quot),
    .rem_o    (w_rem)
  );

  assign w_prod_fix = neg_q ? (-w_prod) : w_prod;
  assign w_quot_fix = neg_q ? (-w_quot) : w_quot;
  assign w_rem_fix  = neg_q ? (-w_rem)  : w_rem;

  always_comb begin
    case (f3_q)
      F3_MUL:                       w_final_res = w_prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_final_res = w_prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              w_final_res = w_quot_fix;
      default:                      w_final_res = w_rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    w_load   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (w_accept) begin
          f3_d  = bus.ALUctrl_f3;
          neg_d = w_neg;
          if (w_div0 || w_ovf) begin
            state_d  = DONE;
            result_d = w_special_res;
          end else if (FAST_MUL && !bus.ALUctrl_f3[2]) begin
            state_d  = DONE;
            result_d = w_fast_res;
          end else begin
            w_load  = 1'b1;
            state_d = bus.ALUctrl_f3[2] ? DIV : MUL;
          end
        end
      end
      MUL, DIV: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else if (w_last) begin
          state_d  = DONE;
          result_d = w_final_res;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign bus.md_sel = w_md_sel;
  assign bus.busy   = w_busy;
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;

endmodule
`default_nettype wire
